// File: rtl/key_engine_ctrl_if.sv
// Key engine controller bus: digit entry, control strobes, key programming and status outputs.
interface key_engine_ctrl_if #(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MAX_TRIES  = 3
);
    localparam int unsigned KEY_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned TRW   = $clog2(MAX_TRIES + 1);
    localparam int unsigned CW    = $clog2(NUM_DIGITS + 1);

    logic [DIGIT_W-1:0] data;
    logic               data_valid;
    logic               cancel;
    logic               stop;
    logic               prog_valid;
    logic [KEY_W-1:0]   prog_key;

    logic [2:0]         state_o;
    logic               engine_on;
    logic               error;
    logic               locked;
    logic [TRW-1:0]     tries_left;
    logic [CW-1:0]      digit_cnt;

    // Driver side (keypad / host).
    modport master (
        output data, data_valid, cancel, stop, prog_valid, prog_key,
        input  state_o, engine_on, error, locked, tries_left, digit_cnt
    );

    // Controller side.
    modport slave (
        input  data, data_valid, cancel, stop, prog_valid, prog_key,
        output state_o, engine_on, error, locked, tries_left, digit_cnt
    );
endinterface

// File: rtl/key_engine_ctrl.sv
// Engine-start lock controller: assembles a multi-digit key, compares it with a
// programmable stored key and sequences RUN / ERROR / LOCKOUT windows.
module key_engine_ctrl #(
    parameter int unsigned                    DIGIT_W       = 4,
    parameter int unsigned                    NUM_DIGITS    = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0]  KEY_INIT      = 16'h1234,
    parameter int unsigned                    MAX_TRIES     = 3,
    parameter int unsigned                    RUN_CYCLES    = 8,
    parameter int unsigned                    ERR_CYCLES    = 4,
    parameter int unsigned                    LOCK_CYCLES   = 16,
    parameter int unsigned                    ENTRY_TIMEOUT = 32
) (
    input  logic              clock,
    input  logic              reset,
    key_engine_ctrl_if.slave  bus
);
    localparam int unsigned KEY_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned TRW   = $clog2(MAX_TRIES + 1);
    localparam int unsigned CW    = $clog2(NUM_DIGITS + 1);

    // One shared timer, wide enough for the longest timed state.
    localparam int unsigned TMAX_A = (RUN_CYCLES > ERR_CYCLES) ? RUN_CYCLES : ERR_CYCLES;
    localparam int unsigned TMAX_B = (LOCK_CYCLES > ENTRY_TIMEOUT) ? LOCK_CYCLES : ENTRY_TIMEOUT;
    localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StCheck   = 3'd2,
        StRun     = 3'd3,
        StError   = 3'd4,
        StLockout = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] buf_q, buf_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TRW-1:0]   fail_q, fail_d;
    logic [TRW-1:0]   tries_q, tries_d;
    logic             engine_q, error_q, locked_q;

    logic [KEY_W-1:0] buf_shift;

    // New digit enters the LSBs, so the first digit ends up in the MSBs.
    assign buf_shift = (buf_q << DIGIT_W) | KEY_W'(bus.data);

    // Next-state logic for the FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        tries_d = tries_q;

        unique case (state_q)
            StIdle: begin
                if (bus.data_valid) begin
                    buf_d   = buf_shift;
                    cnt_d   = CW'(1);
                    state_d = (NUM_DIGITS == 1) ? StCheck : StEntry;
                end
            end

            StEntry: begin
                if (bus.cancel) begin
                    state_d = StIdle;
                end else if (bus.data_valid) begin
                    buf_d   = buf_shift;
                    cnt_d   = cnt_q + 1'b1;
                    timer_d = '0;
                    if (cnt_q + 1'b1 == CW'(NUM_DIGITS)) begin
                        state_d = StCheck;
                    end
                end else if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StCheck: begin
                if (buf_q == key_q) begin
                    state_d = StRun;
                    fail_d  = '0;
                    tries_d = TRW'(MAX_TRIES);
                end else begin
                    fail_d  = fail_q + 1'b1;
                    tries_d = tries_q - 1'b1;
                    state_d = (fail_q + 1'b1 == TRW'(MAX_TRIES)) ? StLockout : StError;
                end
            end

            StRun: begin
                if (bus.prog_valid) begin
                    key_d = bus.prog_key;
                end
                if (bus.stop || (timer_q == TW'(RUN_CYCLES - 1))) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StError: begin
                if (timer_q == TW'(ERR_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StLockout: begin
                if (timer_q == TW'(LOCK_CYCLES - 1)) begin
                    state_d = StIdle;
                    fail_d  = '0;
                    tries_d = TRW'(MAX_TRIES);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Any state change restarts the timer; arriving in IDLE drops the partial entry.
        if (state_d != state_q) begin
            timer_d = '0;
        end
        if ((state_d == StIdle) && (state_q != StIdle)) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            buf_q    <= '0;
            key_q    <= KEY_INIT;
            cnt_q    <= '0;
            timer_q  <= '0;
            fail_q   <= '0;
            tries_q  <= TRW'(MAX_TRIES);
            engine_q <= 1'b0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
            tries_q  <= tries_d;
            engine_q <= (state_d == StRun);
            error_q  <= (state_d == StError);
            locked_q <= (state_d == StLockout);
        end
    end

    assign bus.state_o    = state_q;
    assign bus.engine_on  = engine_q;
    assign bus.error      = error_q;
    assign bus.locked     = locked_q;
    assign bus.tries_left = tries_q;
    assign bus.digit_cnt  = cnt_q;
endmodule

// File: tb/tb_key_engine_ctrl.sv
// Self-checking bench for key_engine_ctrl: per-cycle compare against a behavioural
// model plus literal checkpoints, and a single-digit parameter variant.
`timescale 1ns/1ps
module tb_key_engine_ctrl;
    logic clk;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;
    int cyc = 0;

    key_engine_ctrl_if #(.DIGIT_W(4), .NUM_DIGITS(4), .MAX_TRIES(3)) b1 ();
    key_engine_ctrl_if #(.DIGIT_W(8), .NUM_DIGITS(1), .MAX_TRIES(3)) b2 ();

    key_engine_ctrl #(
        .DIGIT_W(4), .NUM_DIGITS(4), .KEY_INIT(16'h1234), .MAX_TRIES(3),
        .RUN_CYCLES(8), .ERR_CYCLES(4), .LOCK_CYCLES(16), .ENTRY_TIMEOUT(32)
    ) u_dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (b1)
    );

    key_engine_ctrl #(
        .DIGIT_W(8), .NUM_DIGITS(1), .KEY_INIT(8'h5A), .MAX_TRIES(3),
        .RUN_CYCLES(8), .ERR_CYCLES(4), .LOCK_CYCLES(16), .ENTRY_TIMEOUT(32)
    ) u_dut1 (
        .clock(clk),
        .reset(rst_n),
        .bus  (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Behavioural model of the 4-digit instance ----------------
    // States: 0 idle, 1 entry, 2 check, 3 run, 4 error, 5 lockout.
    // The key is assembled arithmetically and timed states count down what remains.
    int m_state, m_val, m_cnt, m_idle, m_left, m_fails, m_key;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_val <= 0; m_cnt <= 0; m_idle <= 0;
            m_left  <= 0; m_fails <= 0; m_key <= 'h1234;
        end else begin
            case (m_state)
                0: if (b1.data_valid) begin
                    m_val <= int'(b1.data); m_cnt <= 1; m_idle <= 0; m_state <= 1;
                end
                1: begin
                    if (b1.cancel) begin
                        m_state <= 0; m_val <= 0; m_cnt <= 0;
                    end else if (b1.data_valid) begin
                        m_val  <= m_val * 16 + int'(b1.data);
                        m_cnt  <= m_cnt + 1;
                        m_idle <= 0;
                        if (m_cnt + 1 == 4) m_state <= 2;
                    end else if (m_idle + 1 == 32) begin
                        m_state <= 0; m_val <= 0; m_cnt <= 0;
                    end else begin
                        m_idle <= m_idle + 1;
                    end
                end
                2: begin
                    if (m_val == m_key) begin
                        m_state <= 3; m_left <= 8; m_fails <= 0;
                    end else begin
                        m_fails <= m_fails + 1;
                        if (m_fails + 1 == 3) begin
                            m_state <= 5; m_left <= 16;
                        end else begin
                            m_state <= 4; m_left <= 4;
                        end
                    end
                end
                3: begin
                    if (b1.prog_valid) m_key <= int'(b1.prog_key);
                    if (b1.stop || m_left == 1) begin
                        m_state <= 0; m_val <= 0; m_cnt <= 0;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                4: begin
                    if (m_left == 1) begin
                        m_state <= 0; m_val <= 0; m_cnt <= 0;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: begin
                    if (m_left == 1) begin
                        m_state <= 0; m_val <= 0; m_cnt <= 0; m_fails <= 0;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare of every status output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [2:0] e_st;
            logic       e_eng, e_err, e_lck;
            logic [1:0] e_tr;
            logic [2:0] e_cnt;
            cyc++;
            e_st  = 3'(m_state);
            e_eng = (m_state == 3);
            e_err = (m_state == 4);
            e_lck = (m_state == 5);
            e_tr  = 2'(3 - m_fails);
            e_cnt = 3'(m_cnt);
            n_vec++;
            if ({b1.state_o, b1.engine_on, b1.error, b1.locked, b1.tries_left, b1.digit_cnt} !==
                {e_st, e_eng, e_err, e_lck, e_tr, e_cnt}) begin
                n_err++;
                $display("FAIL model cycle %0d: dut st=%0d eng=%b err=%b lck=%b tries=%0d cnt=%0d, expected st=%0d eng=%b err=%b lck=%b tries=%0d cnt=%0d",
                         cyc, b1.state_o, b1.engine_on, b1.error, b1.locked, b1.tries_left,
                         b1.digit_cnt, e_st, e_eng, e_err, e_lck, e_tr, e_cnt);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        b1.data       = d;
        b1.data_valid = 1'b1;
        tick();
        b1.data_valid = 1'b0;
    endtask

    task automatic enter_key(input logic [15:0] k);
        send_digit(k[15:12]);
        send_digit(k[11:8]);
        send_digit(k[7:4]);
        send_digit(k[3:0]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (b1.state_o != 3'd0 && n < 100) begin
            tick();
            n++;
        end
        lit("idle_reached", int'(b1.state_o), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        b1.data = '0; b1.data_valid = 0; b1.cancel = 0; b1.stop = 0;
        b1.prog_valid = 0; b1.prog_key = '0;
        b2.data = '0; b2.data_valid = 0; b2.cancel = 0; b2.stop = 0;
        b2.prog_valid = 0; b2.prog_key = '0;
        tick();
        cmp_en = 1;
        tick();
        lit("reset_state", int'(b1.state_o), 0);
        lit("reset_tries", int'(b1.tries_left), 3);
        lit("reset_cnt", int'(b1.digit_cnt), 0);
        rst_n = 1'b1;
        tick();

        // 1: correct key -> CHECK, RUN for 8 cycles, IDLE.
        enter_key(16'h1234);
        lit("t1_check", int'(b1.state_o), 2);
        tick();
        lit("t1_run", int'(b1.state_o), 3);
        lit("t1_engine", int'(b1.engine_on), 1);
        repeat (7) tick();
        lit("t1_run_last", int'(b1.state_o), 3);
        tick();
        lit("t1_idle", int'(b1.state_o), 0);
        lit("t1_engine_off", int'(b1.engine_on), 0);
        lit("t1_tries", int'(b1.tries_left), 3);

        // 2: three wrong keys -> ERROR, ERROR, LOCKOUT.
        enter_key(16'h1235);
        tick();
        lit("t2_err1", int'(b1.error), 1);
        lit("t2_tries1", int'(b1.tries_left), 2);
        repeat (3) tick();
        lit("t2_err1_last", int'(b1.state_o), 4);
        tick();
        lit("t2_err1_exit", int'(b1.state_o), 0);
        enter_key(16'h1235);
        tick();
        lit("t2_tries2", int'(b1.tries_left), 1);
        wait_idle();
        enter_key(16'h1235);
        tick();
        lit("t2_locked", int'(b1.locked), 1);
        lit("t2_tries0", int'(b1.tries_left), 0);
        send_digit(4'h9);
        send_digit(4'h9);
        send_digit(4'h9);
        repeat (12) tick();
        lit("t2_lock_last", int'(b1.state_o), 5);
        tick();
        lit("t2_lock_exit", int'(b1.state_o), 0);
        lit("t2_tries_restored", int'(b1.tries_left), 3);
        lit("t2_cnt", int'(b1.digit_cnt), 0);

        // 3: cancel beats data_valid; entry timeout.
        send_digit(4'h1);
        send_digit(4'h2);
        lit("t3_cnt2", int'(b1.digit_cnt), 2);
        b1.data = 4'h7; b1.data_valid = 1; b1.cancel = 1;
        tick();
        b1.data_valid = 0; b1.cancel = 0;
        lit("t3_cancel_state", int'(b1.state_o), 0);
        lit("t3_cancel_cnt", int'(b1.digit_cnt), 0);
        lit("t3_cancel_tries", int'(b1.tries_left), 3);
        send_digit(4'h1);
        send_digit(4'h2);
        repeat (31) tick();
        lit("t3_pre_timeout", int'(b1.state_o), 1);
        tick();
        lit("t3_timeout", int'(b1.state_o), 0);

        // 4: reprogram key in RUN; reset restores KEY_INIT.
        enter_key(16'h1234);
        tick();
        b1.prog_valid = 1; b1.prog_key = 16'hABCD;
        tick();
        b1.prog_valid = 0;
        wait_idle();
        enter_key(16'h1234);
        tick();
        lit("t4_old_key_fails", int'(b1.state_o), 4);
        wait_idle();
        enter_key(16'hABCD);
        tick();
        lit("t4_new_key_runs", int'(b1.state_o), 3);
        wait_idle();
        send_digit(4'h1);
        send_digit(4'h2);
        rst_n = 1'b0;
        #1;
        lit("t4_rst_state", int'(b1.state_o), 0);
        lit("t4_rst_cnt", int'(b1.digit_cnt), 0);
        lit("t4_rst_tries", int'(b1.tries_left), 3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enter_key(16'h1234);
        tick();
        lit("t4_init_key_runs", int'(b1.state_o), 3);
        wait_idle();

        // 5: early stop; prog_valid outside RUN is ignored.
        enter_key(16'h1234);
        tick();
        tick();
        tick();
        b1.stop = 1;
        tick();
        b1.stop = 0;
        lit("t5_stop_state", int'(b1.state_o), 0);
        lit("t5_stop_engine", int'(b1.engine_on), 0);
        b1.prog_valid = 1; b1.prog_key = 16'hFFFF;
        tick();
        send_digit(4'h1);
        send_digit(4'h2);
        send_digit(4'h3);
        send_digit(4'h4);
        b1.prog_valid = 0;
        tick();
        lit("t5_key_unchanged", int'(b1.state_o), 3);
        wait_idle();

        // 6: single-digit, 8-bit variant.
        lit("t6_reset", int'(b2.state_o), 0);
        b2.data = 8'h5A; b2.data_valid = 1;
        tick();
        b2.data_valid = 0;
        lit("t6_check", int'(b2.state_o), 2);
        lit("t6_cnt", int'(b2.digit_cnt), 1);
        tick();
        lit("t6_run", int'(b2.state_o), 3);
        repeat (7) tick();
        lit("t6_run_last", int'(b2.engine_on), 1);
        tick();
        lit("t6_idle", int'(b2.state_o), 0);
        b2.data = 8'h5B; b2.data_valid = 1;
        tick();
        b2.data_valid = 0;
        tick();
        lit("t6_error", int'(b2.state_o), 4);
        lit("t6_tries", int'(b2.tries_left), 2);
        repeat (4) tick();

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_engine_ctrl.md
Name: key_engine_ctrl

Overview:
Parametrised engine-start lock controller, the successor to the single-digit cdd key checker. It accepts a multi-digit key one digit per strobe and compares the assembled key with a programmable stored key. A match runs the engine for a timed window; a mismatch gives a timed error. Repeated failures force a lockout. Status outputs drive the seven-segment/LED decode logic downstream.

Parameters:
DIGIT_W, 4, bits per entered digit
NUM_DIGITS, 4, digits per key; KEY_W = DIGIT_W*NUM_DIGITS
KEY_INIT, 16'h1234, stored key after reset (KEY_W bits)
MAX_TRIES, 3, consecutive failures that trigger LOCKOUT (>=1)
RUN_CYCLES, 8, cycles engine_on is held in RUN (>=1)
ERR_CYCLES, 4, cycles spent in ERROR (>=1)
LOCK_CYCLES, 16, cycles spent in LOCKOUT (>=1)
ENTRY_TIMEOUT, 32, idle cycles in ENTRY before abandoning entry (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
data  in  DIGIT_W  key digit
data_valid  in  1  one-cycle digit strobe
cancel  in  1  abort current entry
stop  in  1  end RUN early
prog_valid  in  1  load new key (honoured only in RUN)
prog_key  in  KEY_W  new key value
state_o  out  3  IDLE=0 ENTRY=1 CHECK=2 RUN=3 ERROR=4 LOCKOUT=5
engine_on  out  1  high exactly while in RUN
error  out  1  high exactly while in ERROR
locked  out  1  high exactly while in LOCKOUT
tries_left  out  clog2(MAX_TRIES+1)  MAX_TRIES minus consecutive failures
digit_cnt  out  clog2(NUM_DIGITS+1)  digits captured in current entry

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, entry buffer 0, digit_cnt 0, timer 0, fail count 0, tries_left=MAX_TRIES, stored key=KEY_INIT. engine_on, error and locked are all 0.
- Reset mid-operation aborts at once. A key loaded by prog_valid is not retained: the stored key returns to KEY_INIT.
- All outputs are registered. engine_on, error and locked are decoded from the state register.
- Digit capture: the buffer shifts left by DIGIT_W and data enters the LSBs. The first digit entered ends up in the MSBs.
- IDLE: data_valid captures a digit, sets digit_cnt=1 and moves to ENTRY. If NUM_DIGITS==1, it moves to CHECK instead. cancel, stop and prog_valid are ignored.
- ENTRY:
  - data_valid captures a digit, increments digit_cnt and clears the timeout timer.
  - When the captured digit is number NUM_DIGITS, the next state is CHECK.
  - cancel returns to IDLE and clears the buffer and digit_cnt; it is not a failure. cancel wins over a simultaneous data_valid.
  - After ENTRY_TIMEOUT consecutive cycles with no data_valid, go to IDLE as for cancel.
- CHECK lasts exactly one cycle. data_valid is ignored.
  - Buffer == stored key: go to RUN, clear the fail count, set tries_left=MAX_TRIES.
  - Mismatch: fail count +1 and tries_left -1. If the fail count reaches MAX_TRIES, go to LOCKOUT; otherwise go to ERROR.
- RUN: engine_on=1 for exactly RUN_CYCLES cycles, then IDLE.
  - stop goes to IDLE on the next edge.
  - prog_valid latches prog_key into the stored key on that edge. prog_valid together with stop applies both.
- ERROR: lasts exactly ERR_CYCLES cycles, then IDLE. The fail count is retained.
- LOCKOUT: lasts exactly LOCK_CYCLES cycles, then IDLE. On exit, clear the fail count and set tries_left=MAX_TRIES.
- Latency: the final digit strobe at edge N gives CHECK at N+1 and RUN, ERROR or LOCKOUT at N+2.
- data_valid is ignored in CHECK, RUN, ERROR and LOCKOUT; those digits are discarded, not queued.
- Entering IDLE always clears the buffer and digit_cnt.
- The timer is one shared counter, sized for the largest cycle parameter. It clears on every state change.

Test Plan:
1. Reset, then strobe 1,2,3,4 on consecutive cycles -> CHECK one cycle after digit 4, RUN the cycle after. engine_on high 8 cycles, then IDLE; tries_left=3.
2. Enter 1,2,3,5 -> ERROR for 4 cycles with error=1, tries_left=2. Repeat twice more -> the third failure goes to LOCKOUT, locked=1 for 16 cycles. Then IDLE with tries_left=3. data_valid during LOCKOUT has no effect.
3. Enter 1,2, then cancel together with data_valid=7 -> IDLE, digit_cnt=0, tries_left unchanged. Enter 1,2, then idle 32 cycles -> IDLE at timeout.
4. In RUN, assert prog_valid with prog_key=16'hABCD -> 1,2,3,4 now fails and A,B,C,D succeeds. Assert reset low mid-entry -> all outputs return to reset values; 1,2,3,4 succeeds again.
5. In RUN, assert stop on cycle 3 -> IDLE on the next edge, engine_on low. prog_valid in IDLE or ENTRY -> stored key unchanged.
6. Parameter sweep with NUM_DIGITS=1, DIGIT_W=8, KEY_INIT=8'h5A: a single strobe of 8'h5A -> CHECK next cycle, then RUN. 8'h5B -> ERROR.
